iq_symbol_assembler: RTL and testbench

Parametrised serial-to-parallel I/Q symbol assembler for the OFDM transmit path.
- Collects NUM_SC mapped I/Q samples of DATA_W bits, one per handshake, into one parallel symbol word per rail (I and Q).
- Presents the symbol to the IFFT stage with valid/ready backpressure.
- Successor to the fixed 16-bit/4-slot dual symbol generator: adds clocked handshaking, a second buffer stage, flush and symbol counting.

---
 rtl/iq_symbol_assembler.sv | 141 ++++++++++++++
 tb/tb_iq_symbol_assembler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_symbol_assembler.sv
// iq_symbol_assembler: serial-to-parallel I/Q symbol assembler for the OFDM
// transmit path. Collects NUM_SC samples per rail into one symbol word, with
// a second (accumulator) buffer stage, valid/ready handshakes on both sides,
// a synchronous flush and a delivered-symbol counter.
// Optional build macro: PILOT_INSERT_EN (slot PILOT_IDX carries PILOT_I/PILOT_Q
// and the slot counter skips it).
module iq_symbol_assembler #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_SC    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PILOT_IDX = 0,
    parameter logic [DATA_W-1:0] PILOT_I = DATA_W'(16'h0014),
    parameter logic [DATA_W-1:0] PILOT_Q = DATA_W'(16'h0014)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        in_phase,
    input  logic [DATA_W-1:0]        quad_phase,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W*NUM_SC-1:0] out_phase,
    output logic [DATA_W*NUM_SC-1:0] out_quad,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         sym_cnt
);

    localparam int unsigned SYM_W = DATA_W * NUM_SC;
    localparam int unsigned K_W   = $clog2(NUM_SC);

`ifdef PILOT_INSERT_EN
    // The pilot slot is never written by data, so the counter starts past it
    // when it sits at slot 0 and stops short of it when it is the top slot.
    localparam int unsigned FIRST_SLOT = (PILOT_IDX == 0) ? 1 : 0;
    localparam int unsigned LAST_SLOT  = (PILOT_IDX == NUM_SC - 1) ? NUM_SC - 2 : NUM_SC - 1;
`else
    localparam int unsigned FIRST_SLOT = 0;
    localparam int unsigned LAST_SLOT  = NUM_SC - 1;
    logic unused_pilot;
    assign unused_pilot = ^{PILOT_I, PILOT_Q, PILOT_IDX};
`endif

    logic [K_W-1:0]   slot;
    logic [K_W-1:0]   slot_next;
    logic             acc_full;
    logic [SYM_W-1:0] acc_i;
    logic [SYM_W-1:0] acc_q;
    logic [SYM_W-1:0] sym_i;
    logic [SYM_W-1:0] sym_q;
    logic             accept;
    logic             complete;
    logic             drain;
    logic             out_free;

    assign in_ready = !acc_full;
    assign accept   = in_valid && !acc_full;
    assign complete = accept && (slot == K_W'(LAST_SLOT));
    assign drain    = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    // Next slot index, wrapping at the last data slot and stepping over the pilot.
    always_comb begin
        slot_next = slot + K_W'(1);
        if (slot == K_W'(LAST_SLOT)) begin
            slot_next = K_W'(FIRST_SLOT);
        end
`ifdef PILOT_INSERT_EN
        else if (slot + K_W'(1) == K_W'(PILOT_IDX)) begin
            slot_next = slot + K_W'(2);
        end
`endif
    end

    // Accumulator contents with the sample being accepted this cycle merged in,
    // so a completing symbol can go straight to the output stage.
    always_comb begin
        sym_i = acc_i;
        sym_q = acc_q;
        for (int unsigned j = 0; j < NUM_SC; j++) begin
            if (accept && (slot == K_W'(j))) begin
                sym_i[j*DATA_W +: DATA_W] = in_phase;
                sym_q[j*DATA_W +: DATA_W] = quad_phase;
            end
        end
`ifdef PILOT_INSERT_EN
        sym_i[PILOT_IDX*DATA_W +: DATA_W] = PILOT_I;
        sym_q[PILOT_IDX*DATA_W +: DATA_W] = PILOT_Q;
`endif
    end

    // Accumulator storage: captures each accepted sample into its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (!clr && accept) begin
            acc_i <= sym_i;
            acc_q <= sym_q;
        end
    end

    // Slot counter, second-stage occupancy, output stage and symbol counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= K_W'(FIRST_SLOT);
            acc_full  <= 1'b0;
            out_valid <= 1'b0;
            out_phase <= '0;
            out_quad  <= '0;
            sym_cnt   <= '0;
        end else if (clr) begin
            slot      <= K_W'(FIRST_SLOT);
            acc_full  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                slot <= slot_next;
            end
            if (drain) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
            // A parked symbol always wins the output stage on a drain; no
            // sample can be accepted while it is parked, so acc is complete.
            if (acc_full && drain) begin
                out_phase <= acc_i;
                out_quad  <= acc_q;
                acc_full  <= 1'b0;
            end else if (complete && out_free) begin
                out_phase <= sym_i;
                out_quad  <= sym_q;
                out_valid <= 1'b1;
            end else if (complete) begin
                acc_full <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iq_symbol_assembler.sv
// Self-checking bench for iq_symbol_assembler (default build, no pilot).
// A transaction-level model (sample queue -> symbol queue) predicts the outputs;
// a compare process checks them every falling edge, and directed steps add
// hand-computed literal checks.
module tb_iq_symbol_assembler;

    localparam int unsigned DW = 16;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr = 1'b0;
    logic [DW-1:0]   in_phase = '0;
    logic [DW-1:0]   quad_phase = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW*NS-1:0] out_phase;
    logic [DW*NS-1:0] out_quad;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   sym_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    iq_symbol_assembler #(.DATA_W(DW), .NUM_SC(NS), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_phase   (in_phase),
        .quad_phase (quad_phase),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_phase  (out_phase),
        .out_quad   (out_quad),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sym_cnt    (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Completed symbols not yet handed off downstream; front = what is shown.
    logic [DW*NS-1:0] mq_i[$];
    logic [DW*NS-1:0] mq_q[$];
    logic [DW-1:0]    part_i[$];
    logic [DW-1:0]    part_q[$];
    logic [DW*NS-1:0] last_i = '0;
    logic [DW*NS-1:0] last_q = '0;
    int unsigned      m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_i.delete(); mq_q.delete(); part_i.delete(); part_q.delete();
            last_i = '0; last_q = '0; m_cnt = 0;
        end else if (clr) begin
            if (mq_i.size() > 0) begin
                last_i = mq_i[0];
                last_q = mq_q[0];
            end
            mq_i.delete(); mq_q.delete(); part_i.delete(); part_q.delete();
        end else begin
            automatic bit can_acc = (mq_i.size() < 2);
            automatic bit drn = (mq_i.size() > 0) && out_ready;
            if (drn) begin
                last_i = mq_i.pop_front();
                last_q = mq_q.pop_front();
                m_cnt++;
            end
            if (in_valid && can_acc) begin
                part_i.push_back(in_phase);
                part_q.push_back(quad_phase);
                if (part_i.size() == NS) begin
                    automatic logic [DW*NS-1:0] si = '0;
                    automatic logic [DW*NS-1:0] sq = '0;
                    for (int k = 0; k < NS; k++) begin
                        si[k*DW +: DW] = part_i[k];
                        sq[k*DW +: DW] = part_q[k];
                    end
                    mq_i.push_back(si);
                    mq_q.push_back(sq);
                    part_i.delete(); part_q.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (mq_i.size() > 0) begin
                chk("out_valid", 64'(out_valid), 64'd1);
                chk("out_phase", out_phase, mq_i[0]);
                chk("out_quad", out_quad, mq_q[0]);
            end else begin
                chk("out_valid", 64'(out_valid), 64'd0);
                chk("out_phase_hold", out_phase, last_i);
                chk("out_quad_hold", out_quad, last_q);
            end
            chk("in_ready", 64'(in_ready), 64'(mq_i.size() < 2));
            chk("sym_cnt", 64'(sym_cnt), 64'(m_cnt[CW-1:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [DW-1:0] i, input logic [DW-1:0] q);
        @(negedge clk);
        in_phase   = i;
        quad_phase = q;
        in_valid   = 1'b1;
    endtask

    task automatic stop_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        #22;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_sym_cnt", 64'(sym_cnt), 64'd0);
        chk("reset_out_phase", out_phase, 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic fill
        out_ready = 1'b1;
        send(16'h0014, 16'h0028);
        send(16'h000A, 16'h0028);
        send(16'h0028, 16'h0028);
        send(16'h001E, 16'h0028);
        stop_in();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_phase", out_phase, 64'h001E_0028_000A_0014);
        chk("basic_quad", out_quad, 64'h0028_0028_0028_0028);
        @(negedge clk);
        chk("basic_cnt", 64'(sym_cnt), 64'd1);
        chk("basic_valid_drop", 64'(out_valid), 64'd0);

        // Streaming: 16 back-to-back samples
        for (int j = 0; j < 16; j++) begin
            send(16'h0100 + 16'(j * 7), 16'hF000 - 16'(j * 3));
        end
        stop_in();
        repeat (2) @(negedge clk);
        chk("stream_cnt", 64'(sym_cnt), 64'd5);

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            send(16'h2000 + 16'(j), 16'h3000 + 16'(j));
        end
        send(16'h2008, 16'h3008);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_first_sym", out_phase, 64'h2003_2002_2001_2000);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_cnt", 64'(sym_cnt), 64'd6);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_second_sym", out_phase, 64'h2007_2006_2005_2004);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        stop_in();

        // Flush: partial (9th sample + two more) discarded
        out_ready = 1'b1;
        send(16'hAAAA, 16'h5555);
        send(16'hBBBB, 16'h6666);
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        send(16'h0001, 16'h0011);
        send(16'h0002, 16'h0022);
        send(16'h0003, 16'h0033);
        send(16'h0004, 16'h0044);
        stop_in();
        chk("flush_phase", out_phase, 64'h0004_0003_0002_0001);
        chk("flush_quad", out_quad, 64'h0044_0033_0022_0011);
        @(negedge clk);
        chk("flush_cnt", 64'(sym_cnt), 64'd8);

        // Reset mid-operation with output valid and accumulator full
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            send(16'h4000 + 16'(j), 16'h5000 + 16'(j));
        end
        stop_in();
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sym_cnt", 64'(sym_cnt), 64'd0);
        chk("rst_out_phase", out_phase, 64'd0);
        chk("rst_out_quad", out_quad, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0101, 16'hF001);
        send(16'h0202, 16'hF002);
        send(16'h0303, 16'hF003);
        send(16'h0404, 16'hF004);
        stop_in();
        chk("post_rst_phase", out_phase, 64'h0404_0303_0202_0101);
        chk("post_rst_quad", out_quad, 64'hF004_F003_F002_F001);
        repeat (3) @(negedge clk);
        chk("post_rst_cnt", 64'(sym_cnt), 64'd1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
